sr04_scan_scheduler: RTL
========================

Name: sr04_scan_scheduler

Overview:
- Round-robin scheduler that shares one sr04_controller between NUM_CH ultrasonic sensors.
- Drives the trigger/echo mux select, pulses the controller start, and waits for a result or a timeout.
- Stores one distance per channel and enforces an inter-shot holdoff so echoes from different sensors do not cross-talk.
- Sits between the top-level sensor mux and the display/UART readout.

Parameters:
- NUM_CH, 4, number of sensors scanned (2..8).
- CH_W, 2, width of the channel index; must satisfy 2**CH_W >= NUM_CH.
- TIMEOUT_US, 30000, maximum wait for a result after start, in us ticks.
- HOLDOFF_US, 60000, idle gap after each measurement before the next channel, in us ticks.

Ports:
- iClk  in  1  system clock, 100 MHz.
- iRstn  in  1  asynchronous active-low reset.
- iTickUs  in  1  1-cycle pulse every 1 us.
- iEnable  in  1  level; high = scan continuously.
- iDistanceCm  in  10  distance from sr04_controller.
- iDistanceValid  in  1  result-valid flag from sr04_controller.
- oStart  out  1  1-cycle start pulse to sr04_controller.
- oSel  out  CH_W  active channel index to the trig/echo mux.
- iRdSel  in  CH_W  readout channel select.
- oRdDistanceCm  out  10  stored distance of channel iRdSel (combinational read).
- oTimeoutMask  out  NUM_CH  bit i set = last shot on channel i timed out.
- oFrameDone  out  1  1-cycle pulse when the last channel of a scan completes.
- oBusy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (iRstn low, asynchronous): state IDLE; oStart=0; oSel=0; oFrameDone=0; oBusy=0; oTimeoutMask=0; all stored distances=0; us counter=0.
- State IDLE: if iEnable=1, go to SETTLE with oSel unchanged (0 after reset).
- State SETTLE: exactly 1 clock, lets the mux switch. Then go to START.
- State START: oStart=1 for exactly this cycle. Clear the us counter. Go to WAIT.
- State WAIT:
  - Count iTickUs pulses.
  - A rising edge of iDistanceValid (0->1 versus the previous cycle) stores iDistanceCm into slot oSel, clears timeout bit oSel, and goes to HOLDOFF.
  - A level already high on entry to WAIT is ignored; only a fresh edge counts.
  - If the counter reaches TIMEOUT_US before an edge: store 10'h3FF, set timeout bit oSel, go to HOLDOFF.
  - If the edge and the timeout terminal count occur in the same cycle, the valid edge wins.
- State HOLDOFF:
  - Clear the counter on entry; count iTickUs pulses up to HOLDOFF_US.
  - On completion, advance oSel to the next channel; oSel wraps from NUM_CH-1 to 0.
  - On wrap, pulse oFrameDone for 1 cycle, in the same cycle oSel changes.
  - Next state: SETTLE if iEnable=1, else IDLE.
- iEnable deasserted mid-scan: the current channel completes through HOLDOFF, then the block goes to IDLE. It never aborts inside WAIT.
- oSel is stable from SETTLE through HOLDOFF of the same channel; it changes only at the HOLDOFF exit.
- Counter: 17 bits minimum, saturating; it must never wrap within one state.
- Readout: iRdSel >= NUM_CH returns 0.

Optional Feature:
- Macro SR04_CH_MASK_EN.
- Defined: adds input iChMask [NUM_CH]. A channel with its mask bit 0 is skipped at the HOLDOFF exit, at zero cost in cycles; oSel advances to the next enabled channel.
  - If all mask bits are 0, the block stays in IDLE.
  - oFrameDone still fires when the index wraps.
- Undefined: no port; all channels are scanned in order.

Decomposition:
- Package sr04_pkg:
  - state encoding constants: IDLE, SETTLE, START, WAIT, HOLDOFF.
  - DIST_W=10.
  - DIST_TIMEOUT=10'h3FF.
- Sub-module sr04_us_counter: a saturating counter with clear, tick-enable and a compare-against-limit output. It is shared by the WAIT and HOLDOFF states.
- Everything else stays flat.

Test Plan (bench with NUM_CH=4, TIMEOUT_US=1000, HOLDOFF_US=100, behavioural controller model):
- Normal scan: iEnable=1; model returns 10, 20, 30, 40 on ch0..3 -> slots hold 10/20/30/40, oTimeoutMask=0000, one oFrameDone after ch3, oSel cycles 0,1,2,3,0.
- Timeout: model never asserts valid on ch2 -> exactly 1000 us after that channel's oStart, slot2=0x3FF, oTimeoutMask=0100; scan continues to ch3.
- Handshake timing: oStart high for exactly 1 cycle, 1 cycle after oSel settles; a stale iDistanceValid=1 held from the previous channel does not complete the new channel.
- Enable drop: deassert iEnable during ch1 WAIT -> ch1 result stored, HOLDOFF of 100 us completes, block goes to IDLE with oSel=2 and oBusy=0.
- Async reset: pull iRstn low mid-WAIT -> all outputs are at their reset values before the next clock edge; after release with iEnable=1 the scan restarts at ch0.
- SR04_CH_MASK_EN with iChMask=1010: only ch1 and ch3 are triggered; oFrameDone fires after ch3; with iChMask=0000 oBusy stays 0.

Source files
------------

// File: rtl/sr04_pkg.sv
// rtl/sr04_pkg.sv - shared state encoding and constants for the sr04 scan scheduler
package sr04_pkg;

    localparam int DIST_W = 10;
    localparam logic [DIST_W-1:0] DIST_TIMEOUT = 10'h3FF;

    // Narrowest microsecond counter; covers the default 60000 us holdoff
    localparam int CNT_MIN_W = 17;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        HOLDOFF = 3'd4
    } state_e;

endpackage

// File: rtl/sr04_us_counter.sv
// rtl/sr04_us_counter.sv - saturating microsecond counter with clear and limit compare
module sr04_us_counter #(
    parameter int CNT_W = 17
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iClr,
    input  logic             iTick,
    input  logic [CNT_W-1:0] iLimit,
    output logic             oDone
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; ticks stop at all-ones so a long state never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iTick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oDone = (cnt_q >= iLimit);

endmodule

// File: rtl/sr04_scan_scheduler.sv
// rtl/sr04_scan_scheduler.sv - round-robin SR04 scan scheduler; SR04_CH_MASK_EN adds a channel skip mask
module sr04_scan_scheduler
    import sr04_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int TIMEOUT_US = 30000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iTickUs,
    input  logic              iEnable,
    input  logic [DIST_W-1:0] iDistanceCm,
    input  logic              iDistanceValid,
`ifdef SR04_CH_MASK_EN
    input  logic [NUM_CH-1:0] iChMask,
`endif
    output logic              oStart,
    output logic [CH_W-1:0]   oSel,
    input  logic [CH_W-1:0]   iRdSel,
    output logic [DIST_W-1:0] oRdDistanceCm,
    output logic [NUM_CH-1:0] oTimeoutMask,
    output logic              oFrameDone,
    output logic              oBusy
);

    localparam int LIM_MAX = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
    localparam int CNT_W   = ($clog2(LIM_MAX + 1) > CNT_MIN_W) ? $clog2(LIM_MAX + 1) : CNT_MIN_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                fd_q, fd_d;
    logic                vld_q;
    logic [NUM_CH-1:0]   tmo_q, tmo_d;
    logic [DIST_W-1:0]   dist_q [NUM_CH];

    logic                wr_en;
    logic [DIST_W-1:0]   wr_data;
    logic                cnt_clr;
    logic                cnt_done;
    logic [CNT_W-1:0]    cnt_limit;
    logic                vld_rise;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [CH_W-1:0]     nxt_sel;
    logic                nxt_wrap;
    logic [CH_W-1:0]     idle_sel;
    logic                scan_ok;

    // Only a fresh 0->1 of the controller's valid finishes a shot
    assign vld_rise  = iDistanceValid & ~vld_q;
    assign ch_onehot = NUM_CH'(1) << sel_q;
    assign cnt_limit = (state_q == WAIT) ? CNT_W'(TIMEOUT_US) : CNT_W'(HOLDOFF_US);

    sr04_us_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .iClr   (cnt_clr),
        .iTick  (iTickUs),
        .iLimit (cnt_limit),
        .oDone  (cnt_done)
    );

`ifdef SR04_CH_MASK_EN
    // Walk forward from the current channel to the next enabled one, noting a wrap
    always_comb begin
        logic [CH_W-1:0] idx;
        logic            found;
        logic            passed;
        idx      = sel_q;
        found    = 1'b0;
        passed   = 1'b0;
        nxt_sel  = sel_q;
        nxt_wrap = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == LAST_CH) begin
                idx    = '0;
                passed = 1'b1;
            end else begin
                idx = idx + CH_W'(1);
            end
            if (!found && iChMask[idx]) begin
                found    = 1'b1;
                nxt_sel  = idx;
                nxt_wrap = passed;
            end
        end
    end

    assign scan_ok  = |iChMask;
    assign idle_sel = iChMask[sel_q] ? sel_q : nxt_sel;
`else
    // Plain round-robin successor
    always_comb begin
        nxt_wrap = (sel_q == LAST_CH);
        nxt_sel  = nxt_wrap ? '0 : sel_q + CH_W'(1);
    end

    assign scan_ok  = 1'b1;
    assign idle_sel = sel_q;
`endif

    // Scan sequencing: next state, slot write strobe and timeout bookkeeping
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fd_d    = 1'b0;
        tmo_d   = tmo_q;
        wr_en   = 1'b0;
        wr_data = iDistanceCm;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (iEnable && scan_ok) begin
                    state_d = SETTLE;
                    sel_d   = idle_sel;
                end
            end
            SETTLE: begin
                state_d = START;
            end
            START: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (vld_rise) begin
                    wr_en   = 1'b1;
                    wr_data = iDistanceCm;
                    tmo_d   = tmo_q & ~ch_onehot;
                    cnt_clr = 1'b1;
                    state_d = HOLDOFF;
                end else if (cnt_done) begin
                    wr_en   = 1'b1;
                    wr_data = DIST_TIMEOUT;
                    tmo_d   = tmo_q | ch_onehot;
                    cnt_clr = 1'b1;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_done) begin
                    sel_d   = nxt_sel;
                    fd_d    = nxt_wrap;
                    state_d = (iEnable && scan_ok) ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers and valid history
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            fd_q    <= 1'b0;
            vld_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
            vld_q   <= iDistanceValid;
            tmo_q   <= tmo_d;
        end
    end

    // Per-channel distance slots, written at the end of each shot
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dist_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_q == CH_W'(i)) begin
                    dist_q[i] <= wr_data;
                end
            end
        end
    end

    // Combinational readout; unused channel indices read as zero
    always_comb begin
        oRdDistanceCm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (iRdSel == CH_W'(i)) begin
                oRdDistanceCm = dist_q[i];
            end
        end
    end

    assign oStart       = (state_q == START);
    assign oSel         = sel_q;
    assign oTimeoutMask = tmo_q;
    assign oFrameDone   = fd_q;
    assign oBusy        = (state_q != IDLE);

endmodule
